// File: rtl/bubblesort_param.sv
`default_nettype none
// ============================================================================
// Module   : bubblesort_param
// Brief    : Serial-load, odd-even transposition sorter with early exit,
//            parallel result bus and one-word-per-cycle read stream.
// Revision : 1.0 - initial release
// ============================================================================
module bubblesort_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 10,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic                    descend,
    input  logic                    rd_en,
    output logic                    full,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       rd_data,
    output logic [DEPTH*DATA_W-1:0] dat_out,
    output logic [CNT_W-1:0]        phases
);

    localparam int                IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  c_depth      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_last_phase = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  c_last_idx   = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DEPTH-1:0][DATA_W-1:0] w_mem_sorted;
    logic [CNT_W-1:0]            r_wr_cnt;
    logic [CNT_W-1:0]            r_phase;
    logic [CNT_W-1:0]            r_phases;
    logic [IDX_W-1:0]            r_rd_ptr;
    logic [IDX_W-1:0]            w_wr_idx;
    logic                        r_descend;
    logic                        r_swap_prev;
    logic                        w_swapped;
    logic                        w_full;
    logic                        w_start_ok;
    logic                        w_wr_ok;
    logic                        w_pop;
    logic                        w_pop_last;
    logic                        w_sort_end;

    assign w_full     = (r_wr_cnt == c_depth);
    assign w_wr_idx   = r_wr_cnt[IDX_W-1:0];
    assign w_start_ok = (r_state == ST_LOAD) && start && w_full;
    assign w_wr_ok    = (r_state == ST_LOAD) && wr_en && !w_full;
    assign w_pop      = (r_state == ST_DONE) && rd_en;
    assign w_pop_last = w_pop && (r_rd_ptr == c_last_idx);
    // Two consecutive swap-free phases cover every adjacent pair, so the array is ordered.
    assign w_sort_end = ((r_phase != '0) && !w_swapped && !r_swap_prev) ||
                        (r_phase == c_last_phase);

    always_comb begin
        w_mem_sorted = r_mem;
        w_swapped    = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (((i % 2) == 1) == r_phase[0]) begin
                if (r_descend ? (r_mem[i] < r_mem[i+1]) : (r_mem[i] > r_mem[i+1])) begin
                    w_mem_sorted[i]   = r_mem[i+1];
                    w_mem_sorted[i+1] = r_mem[i];
                    w_swapped         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (w_start_ok) w_state_nxt = ST_SORT;
            ST_SORT: if (w_sort_end) w_state_nxt = ST_DONE;
            ST_DONE: if (w_pop_last) w_state_nxt = ST_LOAD;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem       <= '0;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_phase     <= '0;
            r_phases    <= '0;
            r_descend   <= 1'b0;
            r_swap_prev <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_start_ok) begin
                        r_descend   <= descend;
                        r_phase     <= '0;
                        r_phases    <= '0;
                        r_swap_prev <= 1'b0;
                    end else if (w_wr_ok) begin
                        r_mem[w_wr_idx] <= wr_data;
                        r_wr_cnt        <= r_wr_cnt + CNT_W'(1);
                    end
                end
                ST_SORT: begin
                    r_mem       <= w_mem_sorted;
                    r_swap_prev <= w_swapped;
                    if (w_sort_end) begin
                        r_phases <= r_phase + CNT_W'(1);
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (w_pop_last) begin
                        r_rd_ptr <= '0;
                        r_wr_cnt <= '0;
                    end else if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign full    = w_full;
    assign busy    = (r_state == ST_SORT);
    assign done    = (r_state == ST_DONE);
    assign rd_data = r_mem[r_rd_ptr];
    assign dat_out = r_mem;
    assign phases  = r_phases;

endmodule
`default_nettype wire

// File: tb/tb_bubblesort_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubblesort_param
// Brief    : Directed self-checking bench for bubblesort_param (10x16 and 2x8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bubblesort_param;

    logic         clk;
    logic         reset, wr_en, start, descend, rd_en;
    logic [15:0]  wr_data;
    logic         full, busy, done;
    logic [15:0]  rd_data;
    logic [159:0] dat_out;
    logic [3:0]   phases;

    logic         s_reset, s_wr_en, s_start, s_descend, s_rd_en;
    logic [7:0]   s_wr_data;
    logic         s_full, s_busy, s_done;
    logic [7:0]   s_rd_data;
    logic [15:0]  s_dat_out;
    logic [1:0]   s_phases;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    logic [15:0] vec_a    [10];
    logic [15:0] exp_asc  [10];
    logic [15:0] exp_desc [10];
    logic [15:0] ramp_up  [10];
    logic [15:0] ramp_dn  [10];

    bubblesort_param u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .descend(descend), .rd_en(rd_en),
        .full(full), .busy(busy), .done(done), .rd_data(rd_data),
        .dat_out(dat_out), .phases(phases)
    );

    bubblesort_param #(.DATA_W(8), .DEPTH(2)) u_small (
        .clk(clk), .reset(s_reset), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .start(s_start), .descend(s_descend), .rd_en(s_rd_en),
        .full(s_full), .busy(s_busy), .done(s_done), .rd_data(s_rd_data),
        .dat_out(s_dat_out), .phases(s_phases)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load(input logic [15:0] v [10]);
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = v[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // cycles counts negedges from the start edge until done is seen
    task automatic run_sort(input string tag, input logic d, output int cycles);
        start   = 1'b1;
        descend = d;
        @(negedge clk);
        start   = 1'b0;
        descend = 1'b0;
        wr_en   = 1'b0;
        cycles  = 1;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic check_array(input string tag, input logic [15:0] e [10]);
        for (int i = 0; i < 10; i++)
            check($sformatf("%s_dat%0d", tag, i), dat_out[i*16 +: 16], e[i]);
    endtask

    task automatic drain(input string tag, input logic [15:0] e [10]);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_rd%0d", tag, i), rd_data, e[i]);
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        check({tag, "_done_low"}, done, 1'b0);
        check({tag, "_full_low"}, full, 1'b0);
    endtask

    initial begin
        vec_a    = '{16'h500, 16'h10, 16'h300, 16'h1, 16'h50, 16'h100, 16'h2, 16'h10, 16'h50, 16'h3};
        exp_asc  = '{16'h1, 16'h2, 16'h3, 16'h10, 16'h10, 16'h50, 16'h50, 16'h100, 16'h300, 16'h500};
        exp_desc = '{16'h500, 16'h300, 16'h100, 16'h50, 16'h50, 16'h10, 16'h10, 16'h3, 16'h2, 16'h1};
        ramp_up  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
        ramp_dn  = '{16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

        reset = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; descend = 1'b0; rd_en = 1'b0;
        s_reset = 1'b0; s_wr_en = 1'b0; s_wr_data = '0; s_start = 1'b0; s_descend = 1'b0; s_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_phases", phases, 4'd0);
        check("rst_rd_data", rd_data, 16'h0);
        check("rst_dat_out", (dat_out == '0), 1'b1);
        reset = 1'b1;
        s_reset = 1'b1;

        // Mixed data, ascending then descending
        load(vec_a);
        check("a_full", full, 1'b1);
        run_sort("asc", 1'b0, cyc);
        check("asc_latency_le11", (cyc <= 11), 1'b1);
        check_array("asc", exp_asc);
        drain("asc", exp_asc);

        load(vec_a);
        run_sort("desc", 1'b1, cyc);
        check_array("desc", exp_desc);
        drain("desc", exp_desc);

        // Already sorted: early exit after two phases
        load(ramp_up);
        run_sort("up", 1'b0, cyc);
        check("up_phases", phases, 4'd2);
        check("up_latency", cyc, 3);
        check_array("up", ramp_up);
        drain("up", ramp_up);

        // Reversed: worst case uses every phase
        load(ramp_dn);
        run_sort("dn", 1'b0, cyc);
        check("dn_phases", phases, 4'd10);
        check("dn_latency", cyc, 11);
        check_array("dn", ramp_up);
        drain("dn", ramp_up);

        // Early start ignored, overfill dropped, write+start while full takes start
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 16'(i + 1);
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("early_start_busy", busy, 1'b0);
        check("early_start_full", full, 1'b0);
        wr_en = 1'b1; wr_data = 16'd10;
        @(negedge clk);
        check("ten_full", full, 1'b1);
        wr_data = 16'hAAAA;
        repeat (2) @(negedge clk);
        wr_en = 1'b0;
        check("ovf_full", full, 1'b1);
        check_array("ovf", ramp_up);
        wr_en = 1'b1; wr_data = 16'hBBBB;
        run_sort("ws", 1'b0, cyc);
        check("ws_phases", phases, 4'd2);
        check_array("ws", ramp_up);
        drain("ws", ramp_up);

        // Reset on the third SORT cycle
        load(ramp_dn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy_before", busy, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_full", full, 1'b0);
        check("mid_dat_out", (dat_out == '0), 1'b1);
        load(vec_a);
        run_sort("post", 1'b0, cyc);
        check_array("post", exp_asc);
        drain("post", exp_asc);

        // DEPTH=2, DATA_W=8
        s_wr_en = 1'b1; s_wr_data = 8'hFF;
        @(negedge clk);
        s_wr_data = 8'h00;
        @(negedge clk);
        s_wr_en = 1'b0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; cyc = 1;
        while (!s_done && cyc < 20) begin @(negedge clk); cyc++; end
        check("s_done", s_done, 1'b1);
        check("s_phases", s_phases, 2'd2);
        check("s_result", s_dat_out, 16'hFF00);

        s_reset = 1'b0;
        @(negedge clk);
        s_reset = 1'b1;
        check("s_rst_dat", s_dat_out, 16'h0000);
        s_wr_en = 1'b1; s_wr_data = 8'h07;
        repeat (2) @(negedge clk);
        s_wr_en = 1'b0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; cyc = 1;
        while (!s_done && cyc < 20) begin @(negedge clk); cyc++; end
        check("s_eq_done", s_done, 1'b1);
        check("s_eq_phases", s_phases, 2'd2);
        check("s_eq_latency", cyc, 3);
        check("s_eq_result", s_dat_out, 16'h0707);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bubblesort_param.md
# bubblesort_param

Parametrised successor to the fixed 10-entry, 16-bit sorter. It serially loads DEPTH unsigned words, sorts them with odd-even transposition in either ascending or descending order, and ends early once the array is sorted. It presents the result both as a flat parallel bus and as a one-word-per-cycle read stream. It sits between a producer that streams keys in and a consumer that drains sorted keys, and it is reusable in any top-level that needs a small in-place sorter.

## Interface
- DATA_W, 16, key width in bits; keys compare as unsigned.
- DEPTH, 10, number of entries; DEPTH ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of the counters and of `phases`.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; 0 on a clk edge resets the block.
- wr_en  in  1  load strobe; honoured only in LOAD while not full.
- wr_data  in  DATA_W  key written to entry `wr_cnt`.
- start  in  1  begin sort; honoured only in LOAD when full.
- descend  in  1  order select, sampled when start is accepted: 0 ascending, 1 descending.
- rd_en  in  1  pop one sorted word; honoured only in DONE.
- full  out  1  all DEPTH entries are loaded.
- busy  out  1  state is SORT.
- done  out  1  state is DONE; sorted data is valid.
- rd_data  out  DATA_W  combinational mem[rd_ptr]; valid while done=1.
- dat_out  out  DEPTH*DATA_W  flat array; entry i is bits [i*DATA_W +: DATA_W].
- phases  out  CNT_W  number of phases executed in the last sort; held until the next accepted start.

## Operation
- States: LOAD, SORT, DONE.
- Reset (reset=0 at an edge): state LOAD; all entries, wr_cnt, rd_ptr, phases, stored descend and swap flags cleared. All outputs read 0, except rd_data, which reads entry 0 (also 0). Reset has priority in every state, including mid-sort.
- LOAD:
  - wr_en with wr_cnt<DEPTH writes mem[wr_cnt] and increments wr_cnt.
  - wr_en when full is ignored; the array and wr_cnt are unchanged.
  - start when not full is ignored.
  - start when full latches descend, clears phases and the phase index, and moves to SORT.
  - wr_en and start in the same cycle while full: the write is dropped and start is taken.
- SORT: one phase per clock edge. Phase index p starts at 0.
  - p even: compare-swap pairs (0,1),(2,3),…
  - p odd: compare-swap pairs (1,2),(3,4),…
  - Ascending swaps when lower>upper; descending swaps when lower<upper. Equal keys never swap.
  - Each phase records whether any swap occurred.
  - wr_en, start and rd_en are ignored.
- Termination, evaluated on the phase just executed (p):
  - If p≥1 and neither phase p nor phase p−1 swapped, go to DONE.
  - Otherwise, if p+1==DEPTH, go to DONE.
  - phases = p+1 on the transition to DONE.
- DONE:
  - rd_en outputs mem[rd_ptr] this cycle and increments rd_ptr.
  - rd_en when rd_ptr==DEPTH−1 instead clears rd_ptr, wr_cnt and full, and returns to LOAD. Array contents are retained until overwritten.
  - dat_out is stable throughout DONE.

## Timing
- Load: full rises the cycle after the DEPTH-th accepted write edge.
- Sort start: the start edge enters SORT; busy=1 from the next cycle. Phase 0 executes on the first edge in SORT.
- Sort latency:
  - N phases occupy N edges; done=1 the cycle after the last phase edge.
  - Total latency from the start edge to done is N+1 cycles, with 2 ≤ N ≤ DEPTH.
  - Already-ordered input gives N=2. Worst case gives N=DEPTH.
- Read: rd_data for index k is valid combinationally while rd_ptr==k. Draining DEPTH words takes DEPTH rd_en cycles. done falls the cycle after the last pop.
- Reset mid-sort: the next cycle shows busy=0, done=0, full=0, dat_out=0.

## Test plan
- Load 0x500,0x10,0x300,0x1,0x50,0x100,0x2,0x10,0x50,0x3; start with descend=0 → done within 11 cycles; dat_out entries 0..9 are 0x1,0x2,0x3,0x10,0x10,0x50,0x50,0x100,0x300,0x500; the 10 rd_en pops return the same sequence, then the block is back in LOAD with full=0.
- Same data with descend=1 → order 0x500 down to 0x1; the stream matches dat_out.
- Load 1..10 ascending, descend=0 → phases=2, done 3 cycles after start, array unchanged. Load 10..1 → phases=10, result 1..10.
- 12 writes in LOAD → only the first 10 are stored; wr_cnt stays at 10. A start pulse before the 10th write is ignored (busy stays 0).
- Assert reset=0 for one cycle on the third SORT cycle → next cycle busy=0, done=0, full=0, dat_out=0. A fresh load and sort afterwards gives the correct result.
- DEPTH=2, DATA_W=8: load 0xFF,0x00, ascending → phases=2, result 0x00,0xFF. Equal keys 0x7,0x7 → no swap, phases=2.
